smi_pixel_rx: RTL

Downstream consumer of the `smi` slave interface. Takes the byte stream the Pi writes over SMI (`smi_out` qualified by `write`) and parses framed pixel data. Packs each three-byte group into a 24-bit GRB pixel and buffers pixels in a small FIFO. Feeds the LED driver stage through a valid/ready handshake.

---
 rtl/smi_pixel_rx_pkg.sv | 19 +
 rtl/smi_pixel_rx_fifo.sv | 48 ++++
 rtl/smi_pixel_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/smi_pixel_rx_pkg.sv
// Shared constants and parser state encoding for the SMI pixel receiver.
// SMI_RX_CHECKSUM_EN adds the CSUM state used by the trailing checksum byte.
package smi_pixel_rx_pkg;

    localparam logic [7:0] SMI_SYNC_BYTE = 8'hA5;
    localparam int         PIXEL_W       = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        PIXEL  = 3'd3
`ifdef SMI_RX_CHECKSUM_EN
        ,
        CSUM   = 3'd4
`endif
    } rx_state_e;

endpackage

// File: rtl/smi_pixel_rx_fifo.sv
// First-word-fall-through pixel FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle. Output reads as zero while empty.
module smi_rx_fifo
    import smi_pixel_rx_pkg::*;
#(
    parameter int WIDTH = PIXEL_W + 1,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB is the wrap bit that tells full apart from empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/smi_pixel_rx.sv
// Parses framed SMI byte stream (A5, len hi, len lo, 3*N payload) into GRB pixels.
// Define SMI_RX_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module smi_pixel_rx
    import smi_pixel_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PIXELS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_write,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               frame_done,
    output logic               frame_err,
    output logic               overflow
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PIXELS);

    rx_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] asm_q, asm_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef SMI_RX_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PIXEL_W:0]   fifo_din;
    logic [PIXEL_W:0]   fifo_dout;

    assign fifo_pop   = !fifo_empty && pix_ready;
    assign pix_valid  = !fifo_empty;
    assign pix_data   = fifo_dout[PIXEL_W-1:0];
    assign pix_last   = fifo_dout[PIXEL_W];
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign overflow   = ovf_q;

    smi_rx_fifo #(
        .WIDTH(PIXEL_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SMI_RX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SMI_RX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fifo_push = 1'b0;
        fifo_din  = {(cnt_q == len_q - 16'd1), asm_q, rx_data};
`ifdef SMI_RX_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        if (rx_write) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SMI_SYNC_BYTE) begin
                        state_d = LEN_HI;
                        ovf_d   = 1'b0;
`ifdef SMI_RX_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                LEN_HI: begin
                    len_d[15:8] = rx_data;
                    state_d     = LEN_LO;
`ifdef SMI_RX_CHECKSUM_EN
                    csum_d      = csum_q ^ rx_data;
`endif
                end
                LEN_LO: begin
                    len_d = {len_q[15:8], rx_data};
`ifdef SMI_RX_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (len_d > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (len_d == 16'd0) begin
`ifdef SMI_RX_CHECKSUM_EN
                        state_d = CSUM;
`else
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = PIXEL;
                        idx_d   = 2'd0;
                        cnt_d   = 16'd0;
                    end
                end
                PIXEL: begin
`ifdef SMI_RX_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    // The third byte completes the pixel; dropped pixels still count.
                    case (idx_q)
                        2'd0: begin
                            asm_d[15:8] = rx_data;
                            idx_d       = 2'd1;
                        end
                        2'd1: begin
                            asm_d[7:0] = rx_data;
                            idx_d      = 2'd2;
                        end
                        default: begin
                            fifo_push = 1'b1;
                            idx_d     = 2'd0;
                            cnt_d     = cnt_q + 16'd1;
                            if (cnt_d == len_q) begin
`ifdef SMI_RX_CHECKSUM_EN
                                state_d = CSUM;
`else
                                done_d  = 1'b1;
                                state_d = IDLE;
`endif
                            end
                        end
                    endcase
                end
`ifdef SMI_RX_CHECKSUM_EN
                CSUM: begin
                    if (rx_data == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

endmodule
